// File: rtl/temporal_pkg.sv
// Shared types and constants for the temporal spike encoder and the
// matching downstream decoder.
package temporal_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    FIRE,
    DONE
  } enc_state_t;

  localparam int DEFAULT_GAMMA_CYCLE_LEN = 16;
  localparam int DEFAULT_PULSE_WIDTH     = 8;

  // Width of a spike-time value; never narrower than one bit.
  function automatic int val_width(input int gamma_len);
    return (gamma_len > 2) ? $clog2(gamma_len) : 1;
  endfunction

endpackage

// File: rtl/gamma_counter.sv
// Saturating gamma-cycle counter: clear restarts at 0, counting stops at MAX_T.
// Shared between the temporal encoder and decoder.
module gamma_counter #(
  parameter  int MAX_T = 16,
  localparam int CNT_W = $clog2(MAX_T + 1)
) (
  input  logic             aclk,
  input  logic             grst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] t
);

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      t <= CNT_W'(MAX_T);
    end else if (clear) begin
      t <= '0;
    end else if (enable && (t != CNT_W'(MAX_T))) begin
      t <= t + CNT_W'(1);
    end
  end

endmodule

// File: rtl/temporal_encoder.sv
// Temporal spike encoder: turns a spike time into a pulse inside the next gamma cycle.
// Optional macro TEMPORAL_NULL_SPIKE_EN: an all-ones value means "never spike".
module temporal_encoder
  import temporal_pkg::*;
#(
  parameter  int GAMMA_CYCLE_LEN = DEFAULT_GAMMA_CYCLE_LEN,
  parameter  int PULSE_WIDTH     = DEFAULT_PULSE_WIDTH,
  localparam int VAL_W           = val_width(GAMMA_CYCLE_LEN),
  localparam int CNT_W           = $clog2(GAMMA_CYCLE_LEN + 1)
) (
  input  logic             aclk,
  input  logic             grst,
  input  logic             gamma_start,
  input  logic             in_valid,
  input  logic [VAL_W-1:0] in_value,
  output logic             in_ready,
  output logic             spike,
  output logic             spike_done
);

  logic [VAL_W-1:0] pend_val_reg, pend_val_next;
  logic             pend_vld_reg, pend_vld_next;
  logic [VAL_W-1:0] act_val_reg, act_val_next;
  logic             act_vld_reg, act_vld_next;
  enc_state_t       state_reg, state_next;
  logic             spike_reg, spike_next;
  logic             spike_done_reg, spike_done_next;
  logic [CNT_W-1:0] t;
  logic [CNT_W-1:0] t_next;
  logic             xfer;
  logic             is_null;
  int               t_i;
  int               v_i;

  gamma_counter #(
    .MAX_T (GAMMA_CYCLE_LEN)
  ) u_gamma_counter (
    .aclk   (aclk),
    .grst   (grst),
    .clear  (gamma_start),
    .enable (1'b1),
    .t      (t)
  );

`ifdef TEMPORAL_NULL_SPIKE_EN
  assign is_null = (pend_val_reg == '1);
`else
  assign is_null = 1'b0;
`endif

  assign in_ready = ~pend_vld_reg;
  assign xfer     = in_valid & ~pend_vld_reg;

  // Outputs are registered from the next-cycle state, so spike in cycle c
  // depends on the counter value that cycle c will see.
  always_comb begin
    t_next        = gamma_start ? '0
                  : (t == CNT_W'(GAMMA_CYCLE_LEN)) ? t : t + CNT_W'(1);
    act_val_next  = act_val_reg;
    act_vld_next  = act_vld_reg;
    if (gamma_start) begin
      act_val_next = pend_val_reg;
      act_vld_next = pend_vld_reg & ~is_null;
    end
    pend_vld_next = xfer | (pend_vld_reg & ~gamma_start);
    pend_val_next = xfer ? in_value : pend_val_reg;

    t_i = 32'(t_next);
    v_i = 32'(act_val_next);
    spike_next = act_vld_next && (t_i >= v_i) && (t_i < v_i + PULSE_WIDTH)
                 && (t_i < GAMMA_CYCLE_LEN);

    if (!act_vld_next) begin
      state_next = IDLE;
    end else if (spike_next) begin
      state_next = FIRE;
    end else if ((t_i < v_i) && (t_i < GAMMA_CYCLE_LEN)) begin
      state_next = WAIT;
    end else begin
      state_next = DONE;
    end

    // A pulse cut short by a new gamma is an abort, not a completion.
    spike_done_next = (state_reg == FIRE) && !spike_next && !gamma_start;
  end

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      pend_val_reg   <= '0;
      pend_vld_reg   <= 1'b0;
      act_val_reg    <= '0;
      act_vld_reg    <= 1'b0;
      state_reg      <= IDLE;
      spike_reg      <= 1'b0;
      spike_done_reg <= 1'b0;
    end else begin
      pend_val_reg   <= pend_val_next;
      pend_vld_reg   <= pend_vld_next;
      act_val_reg    <= act_val_next;
      act_vld_reg    <= act_vld_next;
      state_reg      <= state_next;
      spike_reg      <= spike_next;
      spike_done_reg <= spike_done_next;
    end
  end

  assign spike      = spike_reg;
  assign spike_done = spike_done_reg;

endmodule

// File: tb/tb_temporal_encoder.sv
// Self-checking bench for temporal_encoder (GAMMA_CYCLE_LEN=16, PULSE_WIDTH=8).
module tb_temporal_encoder;

  localparam int G  = 16;
  localparam int PW = 8;
`ifdef TEMPORAL_NULL_SPIKE_EN
  localparam bit NULL_EN = 1'b1;
`else
  localparam bit NULL_EN = 1'b0;
`endif

  logic       aclk = 1'b0;
  logic       grst = 1'b1;
  logic       gamma_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_value = '0;
  logic       in_ready;
  logic       spike;
  logic       spike_done;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic spike;
    logic done;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  temporal_encoder #(
    .GAMMA_CYCLE_LEN (G),
    .PULSE_WIDTH     (PW)
  ) dut (
    .aclk        (aclk),
    .grst        (grst),
    .gamma_start (gamma_start),
    .in_valid    (in_valid),
    .in_value    (in_value),
    .in_ready    (in_ready),
    .spike       (spike),
    .spike_done  (spike_done)
  );

  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Expected outputs for cycles 0..n-1 of a gamma whose active value is v.
  function automatic void push_pulse(input int v, input int n, input bit act);
    exp_t x;
    int   end_c;
    end_c = (v + PW < G) ? v + PW : G;
    for (int c = 0; c < n; c++) begin
      x.spike = act && (v < G) && (c >= v) && (c < v + PW) && (c < G);
      x.done  = act && (v < G) && (c == end_c);
      sb.push_back(x);
    end
  endfunction

  task automatic test_reset();
    #1;
    checks += 3;
    if (spike !== 1'b0) $display("FAIL reset_spike got %b exp 0", spike); else passed++;
    if (spike_done !== 1'b0) $display("FAIL reset_done got %b exp 0", spike_done); else passed++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", in_ready); else passed++;
    tick();
    grst = 1'b0;
    tick();
    $display("reset: spike=%b done=%b ready=%b", spike, spike_done, in_ready);
  endtask

  task automatic test_basic();
    in_valid = 1'b1; in_value = 4'd3;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL basic_ready_pre got %b exp 1", in_ready); else passed++;
    tick();
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL basic_ready_full got %b exp 0", in_ready); else passed++;
    gamma_start = 1'b1; tick(); gamma_start = 1'b0;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL basic_ready_post got %b exp 1", in_ready); else passed++;
    push_pulse(3, 18, 1'b1);
    for (int c = 0; c < 18; c++) begin
      e = sb.pop_front();
      checks += 2;
      if (spike !== e.spike) $display("FAIL basic_spike c=%0d got %b exp %b", c, spike, e.spike); else passed++;
      if (spike_done !== e.done) $display("FAIL basic_done c=%0d got %b exp %b", c, spike_done, e.done); else passed++;
      tick();
    end
    $display("basic: value 3 pulse checked over 18 cycles");
  endtask

  task automatic test_clip();
    in_valid = 1'b1; in_value = 4'd12; tick(); in_valid = 1'b0;
    gamma_start = 1'b1; tick(); gamma_start = 1'b0;
    push_pulse(12, 18, 1'b1);
    for (int c = 0; c < 18; c++) begin
      e = sb.pop_front();
      checks += 2;
      if (spike !== e.spike) $display("FAIL clip_spike c=%0d got %b exp %b", c, spike, e.spike); else passed++;
      if (spike_done !== e.done) $display("FAIL clip_done c=%0d got %b exp %b", c, spike_done, e.done); else passed++;
      tick();
    end
    $display("clip: value 12 pulse checked over 18 cycles");
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_value = 4'd5; tick();
    in_value = 4'd0;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL b2b_holdoff got %b exp 0", in_ready); else passed++;
    tick();
    checks++;
    if (in_ready !== 1'b0) $display("FAIL b2b_holdoff2 got %b exp 0", in_ready); else passed++;
    gamma_start = 1'b1; tick(); gamma_start = 1'b0;
    push_pulse(5, 7, 1'b1);
    for (int c = 0; c < 7; c++) begin
      e = sb.pop_front();
      checks += 2;
      if (spike !== e.spike) $display("FAIL b2b_g1_spike c=%0d got %b exp %b", c, spike, e.spike); else passed++;
      if (spike_done !== e.done) $display("FAIL b2b_g1_done c=%0d got %b exp %b", c, spike_done, e.done); else passed++;
      if (c == 1) begin
        checks++;
        if (in_ready !== 1'b0) $display("FAIL b2b_zero_pending got %b exp 0", in_ready); else passed++;
      end
      if (c == 6) gamma_start = 1'b1;
      tick();
      if (c == 0) in_valid = 1'b0;
    end
    gamma_start = 1'b0;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL b2b_ready_g2 got %b exp 1", in_ready); else passed++;
    push_pulse(0, 18, 1'b1);
    for (int c = 0; c < 18; c++) begin
      e = sb.pop_front();
      checks += 2;
      if (spike !== e.spike) $display("FAIL b2b_g2_spike c=%0d got %b exp %b", c, spike, e.spike); else passed++;
      if (spike_done !== e.done) $display("FAIL b2b_g2_done c=%0d got %b exp %b", c, spike_done, e.done); else passed++;
      tick();
    end
    $display("back_to_back: abort at cycle 6, value 0 in next gamma checked");
  endtask

  task automatic test_null_gamma();
    checks++;
    if (in_ready !== 1'b1) $display("FAIL null_ready_pre got %b exp 1", in_ready); else passed++;
    gamma_start = 1'b1; in_valid = 1'b1; in_value = 4'd2;
    tick();
    gamma_start = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL null_pending got %b exp 0", in_ready); else passed++;
    push_pulse(2, 18, 1'b0);
    for (int c = 0; c < 18; c++) begin
      e = sb.pop_front();
      checks += 2;
      if (spike !== e.spike) $display("FAIL null_spike c=%0d got %b exp %b", c, spike, e.spike); else passed++;
      if (spike_done !== e.done) $display("FAIL null_done c=%0d got %b exp %b", c, spike_done, e.done); else passed++;
      tick();
    end
    gamma_start = 1'b1; tick(); gamma_start = 1'b0;
    push_pulse(2, 18, 1'b1);
    for (int c = 0; c < 18; c++) begin
      e = sb.pop_front();
      checks += 2;
      if (spike !== e.spike) $display("FAIL next_spike c=%0d got %b exp %b", c, spike, e.spike); else passed++;
      if (spike_done !== e.done) $display("FAIL next_done c=%0d got %b exp %b", c, spike_done, e.done); else passed++;
      tick();
    end
    $display("null_gamma: empty gamma then value 2 checked");
  endtask

  task automatic test_all_ones();
    in_valid = 1'b1; in_value = 4'd15; tick(); in_valid = 1'b0;
    gamma_start = 1'b1; tick(); gamma_start = 1'b0;
    push_pulse(15, 18, !NULL_EN);
    for (int c = 0; c < 18; c++) begin
      e = sb.pop_front();
      checks += 2;
      if (spike !== e.spike) $display("FAIL ones_spike c=%0d got %b exp %b", c, spike, e.spike); else passed++;
      if (spike_done !== e.done) $display("FAIL ones_done c=%0d got %b exp %b", c, spike_done, e.done); else passed++;
      tick();
    end
    $display("all_ones: value 15 checked (null_en=%0b)", NULL_EN);
  endtask

  task automatic test_missing_gamma();
    in_valid = 1'b1; in_value = 4'd4; tick(); in_valid = 1'b0;
    push_pulse(4, 6, 1'b0);
    for (int c = 0; c < 6; c++) begin
      e = sb.pop_front();
      checks += 3;
      if (spike !== e.spike) $display("FAIL miss_spike c=%0d got %b exp %b", c, spike, e.spike); else passed++;
      if (spike_done !== e.done) $display("FAIL miss_done c=%0d got %b exp %b", c, spike_done, e.done); else passed++;
      if (in_ready !== 1'b0) $display("FAIL miss_retained c=%0d got %b exp 0", c, in_ready); else passed++;
      tick();
    end
    gamma_start = 1'b1; tick(); gamma_start = 1'b0;
    push_pulse(4, 18, 1'b1);
    for (int c = 0; c < 18; c++) begin
      e = sb.pop_front();
      checks += 2;
      if (spike !== e.spike) $display("FAIL late_spike c=%0d got %b exp %b", c, spike, e.spike); else passed++;
      if (spike_done !== e.done) $display("FAIL late_done c=%0d got %b exp %b", c, spike_done, e.done); else passed++;
      tick();
    end
    $display("missing_gamma: retained value 4 used by late gamma");
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; in_value = 4'd4; tick(); in_valid = 1'b0;
    gamma_start = 1'b1; tick(); gamma_start = 1'b0;
    in_valid = 1'b1; in_value = 4'd9;
    push_pulse(4, 7, 1'b1);
    for (int c = 0; c < 7; c++) begin
      e = sb.pop_front();
      checks += 2;
      if (spike !== e.spike) $display("FAIL rmid_spike c=%0d got %b exp %b", c, spike, e.spike); else passed++;
      if (spike_done !== e.done) $display("FAIL rmid_done c=%0d got %b exp %b", c, spike_done, e.done); else passed++;
      if (c < 6) tick();
      if (c == 0) in_valid = 1'b0;
    end
    grst = 1'b1;
    #1;
    checks += 3;
    if (spike !== 1'b0) $display("FAIL rmid_spike_drop got %b exp 0", spike); else passed++;
    if (in_ready !== 1'b1) $display("FAIL rmid_ready got %b exp 1", in_ready); else passed++;
    if (spike_done !== 1'b0) $display("FAIL rmid_done_rst got %b exp 0", spike_done); else passed++;
    tick(); tick();
    grst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (spike_done !== 1'b0) $display("FAIL rmid_no_done c=%0d got %b exp 0", c, spike_done); else passed++;
    end
    gamma_start = 1'b1; tick(); gamma_start = 1'b0;
    push_pulse(9, 18, 1'b0);
    for (int c = 0; c < 18; c++) begin
      e = sb.pop_front();
      checks += 2;
      if (spike !== e.spike) $display("FAIL lost_spike c=%0d got %b exp %b", c, spike, e.spike); else passed++;
      if (spike_done !== e.done) $display("FAIL lost_done c=%0d got %b exp %b", c, spike_done, e.done); else passed++;
      tick();
    end
    $display("reset_mid: pulse dropped, pending value lost");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clip();
    test_back_to_back();
    test_null_gamma();
    test_all_ones();
    test_missing_gamma();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
